// File: rtl/pixie_fb_scanout_if.sv
// Frame buffer read port between the Pixie scan controller and the dual-port frame buffer.
// The master side issues the enable and address; read data returns one clock after the enable.
interface pixie_fb_scanout_if;
    logic       fb_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    modport master (output fb_en, output fb_addr, input fb_data);
    modport slave  (input fb_en, input fb_addr, output fb_data);
endinterface

// File: rtl/pixie_fb_scanout.sv
// Pixie scan controller: CDP1861-style raster timing, frame buffer byte fetch and
// MSB-first pixel serialisation with vertical line repetition.
module pixie_fb_scanout #(
    parameter int H_TOTAL        = 112,
    parameter int H_START        = 24,
    parameter int BYTES_PER_LINE = 8,
    parameter int HS_START       = 100,
    parameter int HS_LEN         = 12,
    parameter int V_TOTAL        = 262,
    parameter int V_START        = 80,
    parameter int SRC_LINES      = 32,
    parameter int LINE_REP       = 4,
    parameter int VS_LEN         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic               disp_on,
    input  logic [9:0]         base_addr,
    pixie_fb_scanout_if.master fb,
    output logic               pixel,
    output logic               hsync,
    output logic               vsync,
    output logic               hblank,
    output logic               vblank,
    output logic               line_start
);

    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int RW        = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;
    localparam int H_ACT_END = H_START + 8 * BYTES_PER_LINE;
    localparam int V_ACT_END = V_START + SRC_LINES * LINE_REP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_FIRST  = VW'(V_START);
    localparam logic [RW-1:0] REP_LAST = RW'(LINE_REP - 1);

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        REQ_S  = 2'd1,
        WAIT_S = 2'd2,
        LOAD_S = 2'd3
    } fetch_state_e;

    function automatic logic in_win(input int x, input int lo, input int hi);
        return (x >= lo) && (x < hi);
    endfunction

    logic [HW-1:0] h_r, h_next_s;
    logic [VW-1:0] v_r, v_next_s;
    logic          h_wrap_s;
    logic          h_act_next_s, v_act_next_s, v_act_cur_s;
    logic          slot_begin_s, fetch_slot_s, fetch_go_s;
    logic [9:0]    byte_idx_s;

    fetch_state_e  state_r, state_next_s;
    logic [9:0]    frame_base_r, line_addr_r;
    logic [RW-1:0] rep_r;
    logic          disp_line_r;
    logic [7:0]    hold_r, shift_r;

    logic          fb_en_r;
    logic [9:0]    fb_addr_r;
    logic          pixel_r, hsync_r, vsync_r, hblank_r, vblank_r, line_start_r;

    // counter successors and window decode, all evaluated for the position after the next tick
    always_comb begin
        h_wrap_s = (h_r == H_LAST);
        if (h_wrap_s) begin
            h_next_s = '0;
        end else begin
            h_next_s = h_r + HW'(1);
        end
        if (!h_wrap_s) begin
            v_next_s = v_r;
        end else if (v_r == V_LAST) begin
            v_next_s = '0;
        end else begin
            v_next_s = v_r + VW'(1);
        end
        h_act_next_s = in_win(int'(h_next_s), H_START, H_ACT_END);
        v_act_next_s = in_win(int'(v_next_s), V_START, V_ACT_END);
        v_act_cur_s  = in_win(int'(v_r), V_START, V_ACT_END);
        slot_begin_s = h_act_next_s && (((int'(h_next_s) - H_START) % 8) == 0);
        // a fetch is launched one tick ahead of each byte slot: h = H_START-1, H_START+7, ...
        fetch_slot_s = in_win(int'(h_next_s) - (H_START - 1), 0, 8 * BYTES_PER_LINE - 7)
                       && (((int'(h_next_s) - (H_START - 1)) % 8) == 0);
        byte_idx_s   = 10'((int'(h_next_s) - (H_START - 1)) / 8);
        fetch_go_s   = ce_pix && (state_r == IDLE_S) && fetch_slot_s && v_act_cur_s && disp_line_r;
    end

    // fetch sequencer next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE_S: begin
                if (fetch_go_s) begin
                    state_next_s = REQ_S;
                end else begin
                    state_next_s = IDLE_S;
                end
            end
            REQ_S:   state_next_s = WAIT_S;
            WAIT_S:  state_next_s = LOAD_S;
            LOAD_S:  state_next_s = IDLE_S;
            default: state_next_s = IDLE_S;
        endcase
    end

    // raster counters, per-line display enable and source line address (rep counter, no divider)
    always_ff @(posedge clk) begin
        if (reset) begin
            h_r          <= '0;
            v_r          <= '0;
            frame_base_r <= 10'd0;
            line_addr_r  <= 10'd0;
            rep_r        <= '0;
            disp_line_r  <= 1'b0;
        end else if (ce_pix) begin
            h_r <= h_next_s;
            v_r <= v_next_s;
            if (h_wrap_s) begin
                disp_line_r <= disp_on;
                if (v_next_s == '0) begin
                    frame_base_r <= base_addr;
                end
                if (v_next_s == V_FIRST) begin
                    line_addr_r <= frame_base_r;
                    rep_r       <= '0;
                end else if (v_act_next_s) begin
                    if (rep_r == REP_LAST) begin
                        rep_r       <= '0;
                        line_addr_r <= line_addr_r + 10'(BYTES_PER_LINE);
                    end else begin
                        rep_r <= rep_r + RW'(1);
                    end
                end
            end
        end
    end

    // REQ drives the read port for one clock; data valid during WAIT is held from LOAD on
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE_S;
            fb_en_r   <= 1'b0;
            fb_addr_r <= 10'd0;
            hold_r    <= 8'd0;
        end else begin
            state_r <= state_next_s;
            fb_en_r <= fetch_go_s;
            if (fetch_go_s) begin
                fb_addr_r <= line_addr_r + byte_idx_s;
            end
            if (state_r == WAIT_S) begin
                hold_r <= fb.fb_data;
            end
        end
    end

    // pixel shifter and registered sync/blank outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r      <= 8'd0;
            pixel_r      <= 1'b0;
            hsync_r      <= 1'b0;
            vsync_r      <= 1'b0;
            hblank_r     <= 1'b1;
            vblank_r     <= 1'b1;
            line_start_r <= 1'b0;
        end else begin
            line_start_r <= ce_pix && h_wrap_s && v_act_next_s;
            if (ce_pix) begin
                hsync_r  <= in_win(int'(h_next_s), HS_START, HS_START + HS_LEN);
                vsync_r  <= in_win(int'(v_next_s), 0, VS_LEN);
                hblank_r <= !h_act_next_s;
                vblank_r <= !v_act_next_s;
                if (h_act_next_s && v_act_next_s && disp_line_r) begin
                    if (slot_begin_s) begin
                        pixel_r <= hold_r[7];
                        shift_r <= {hold_r[6:0], 1'b0};
                    end else begin
                        pixel_r <= shift_r[7];
                        shift_r <= {shift_r[6:0], 1'b0};
                    end
                end else begin
                    pixel_r <= 1'b0;
                end
            end
        end
    end

    assign fb.fb_en    = fb_en_r;
    assign fb.fb_addr  = fb_addr_r;
    assign pixel       = pixel_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign hblank      = hblank_r;
    assign vblank      = vblank_r;
    assign line_start  = line_start_r;

endmodule

// File: tb/tb_pixie_fb_scanout.sv
// Scoreboard bench for pixie_fb_scanout; vertical timing is shortened so several
// complete frames fit in a short run, horizontal timing is the production one.
module tb_pixie_fb_scanout;

    localparam int H_TOTAL     = 112;
    localparam int H_START     = 24;
    localparam int BPL         = 8;
    localparam int HS_START    = 100;
    localparam int HS_LEN      = 12;
    localparam int V_TOTAL     = 40;
    localparam int V_START     = 12;
    localparam int SRC_LINES   = 4;
    localparam int LINE_REP    = 4;
    localparam int VS_LEN      = 4;
    localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;

    logic       clk;
    logic       reset;
    logic       ce_pix;
    logic       disp_on;
    logic [9:0] base_addr;
    logic       pixel, hsync, vsync, hblank, vblank, line_start;

    pixie_fb_scanout_if bus ();

    pixie_fb_scanout #(
        .H_TOTAL(H_TOTAL), .H_START(H_START), .BYTES_PER_LINE(BPL),
        .HS_START(HS_START), .HS_LEN(HS_LEN), .V_TOTAL(V_TOTAL),
        .V_START(V_START), .SRC_LINES(SRC_LINES), .LINE_REP(LINE_REP), .VS_LEN(VS_LEN)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .disp_on(disp_on),
        .base_addr(base_addr), .fb(bus), .pixel(pixel), .hsync(hsync),
        .vsync(vsync), .hblank(hblank), .vblank(vblank), .line_start(line_start)
    );

    logic [7:0] mem [1024];
    logic [5:0] exp_q [$];
    logic [9:0] addr_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int m_h, m_v, m_base;
    bit m_disp;
    int fetch_cnt, exp_line_fetch, ls_cnt;
    bit cap_en;
    logic [9:0] cap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.fb_en) bus.fb_data <= mem[bus.fb_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (h=%0d v=%0d)", tag, act, exp, m_h, m_v);
        end
    endtask

    // fetch monitor: every read-enable clock must match the next expected address
    always @(negedge clk) begin
        if (line_start) ls_cnt++;
        if (bus.fb_en) begin
            fetch_cnt++;
            if (addr_q.size() == 0) check_eq("fetch_unexpected", bus.fb_en, 1'b0);
            else check_eq("fetch_addr", bus.fb_addr, addr_q.pop_front());
        end
    end

    task automatic model_reset();
        m_h = 0; m_v = 0; m_base = 0; m_disp = 1'b0;
        fetch_cnt = 0; exp_line_fetch = 0; ls_cnt = 0;
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic model_step();
        int nh, nv, src, a;
        bit wrap, hact, vact, pix, hs, vs, ls;
        logic [7:0] b;
        wrap = (m_h == H_TOTAL - 1);
        nh = wrap ? 0 : m_h + 1;
        nv = m_v;
        if (wrap) nv = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        vact = (nv >= V_START) && (nv < V_START + SRC_LINES * LINE_REP);
        hact = (nh >= H_START) && (nh < H_START + 8 * BPL);
        src = (nv - V_START) / LINE_REP;
        if (wrap) begin
            if (nv == 0) m_base = int'(base_addr);
            check_eq("line_fetches", fetch_cnt, exp_line_fetch);
            fetch_cnt = 0;
            m_disp = disp_on;
            exp_line_fetch = (vact && m_disp) ? BPL : 0;
            if (vact && m_disp)
                for (int k = 0; k < BPL; k++) addr_q.push_back(10'((m_base + src * BPL + k) % 1024));
        end
        pix = 1'b0;
        if (hact && vact && m_disp) begin
            a = (m_base + src * BPL + (nh - H_START) / 8) % 1024;
            b = mem[a];
            pix = b[7 - ((nh - H_START) % 8)];
        end
        hs = (nh >= HS_START) && (nh < HS_START + HS_LEN);
        vs = (nv < VS_LEN);
        ls = wrap && vact;
        exp_q.push_back({hs, vs, !hact, !vact, ls, pix});
        m_h = nh;
        m_v = nv;
    endtask

    task automatic do_tick(input bit stop_on_fetch, output bit saw);
        @(negedge clk);
        ce_pix = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        ce_pix = 1'b0;
        check_eq("tick_outs", {hsync, vsync, hblank, vblank, line_start, pixel}, exp_q.pop_front());
        if (cap_en && m_v == V_START) begin
            if (m_h == H_START - 1) cap[9] = pixel;
            else if (m_h >= H_START && m_h < H_START + 8) cap[8 - (m_h - H_START)] = pixel;
            else if (m_h == H_START + 8 * BPL) cap[0] = pixel;
        end
        saw = bus.fb_en;
        if (!(stop_on_fetch && saw)) begin
            @(posedge clk);
            @(posedge clk);
        end
    endtask

    task automatic run_ticks(input int n);
        bit s;
        for (int i = 0; i < n; i++) do_tick(1'b0, s);
    endtask

    task automatic frame_end();
        check_eq("line_starts", ls_cnt, SRC_LINES * LINE_REP);
        ls_cnt = 0;
        check_eq("addr_q_left", addr_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        reset = 1'b1; ce_pix = 1'b0; disp_on = 1'b1; base_addr = 10'h000;
        cap_en = 1'b0; cap = 10'h3FF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {bus.fb_en, pixel, hsync, vsync, hblank, vblank, line_start}, 7'b0000110);
        check_eq("reset_addr", bus.fb_addr, 10'h000);
        @(negedge clk);
        reset = 1'b0;

        // frame 1: base 0; base changed mid-frame must not apply until frame 2
        run_ticks(20 * H_TOTAL);
        base_addr = 10'h3F8;
        run_ticks(FRAME_TICKS - 20 * H_TOTAL);
        frame_end();

        // frame 2: base 0x3F8, source line 1 wraps to 0x000
        run_ticks(20 * H_TOTAL);
        base_addr = 10'h000;
        run_ticks(FRAME_TICKS - 20 * H_TOTAL);
        frame_end();

        // frame 3: 0xA5 at address 0, display disabled mid-line
        mem[0] = 8'hA5;
        cap_en = 1'b1;
        run_ticks(20 * H_TOTAL + 50);
        disp_on = 1'b0;
        run_ticks(10 * H_TOTAL);
        disp_on = 1'b1;
        run_ticks(FRAME_TICKS - 30 * H_TOTAL - 50);
        cap_en = 1'b0;
        frame_end();
        check_eq("a5_row", cap, 10'b0_10100101_0);

        // frame 4: reset while a fetch request is on the bus
        mem[0] = 8'h00;
        saw = 1'b0;
        for (int i = 0; i < 2 * FRAME_TICKS && !saw; i++) do_tick(1'b1, saw);
        check_eq("req_found", saw, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_in_req", {bus.fb_en, pixel, hsync, vsync, hblank, vblank, line_start}, 7'b0000110);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ls_cnt = 0;
        fetch_cnt = 0;

        // frame 5: restarted frame follows the same golden model as frame 1
        run_ticks(FRAME_TICKS);
        frame_end();
        check_eq("exp_q_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
